// File: rtl/bq_pkg.sv
// Shared types and defaults for the broadcast_queue result-collection stage.
package bq_pkg;

  localparam int BQ_NUM_FU_DEFAULT     = 4;
  localparam int BQ_DATA_WIDTH_DEFAULT = 32;
  localparam int BQ_TAG_WIDTH_DEFAULT  = 7;
  localparam int BQ_DEPTH_DEFAULT      = 8;

  typedef logic [BQ_TAG_WIDTH_DEFAULT-1:0]  bq_tag_t;
  typedef logic [BQ_DATA_WIDTH_DEFAULT-1:0] bq_data_t;

  // One queued CDB broadcast: execution tag plus result word.
  typedef struct packed {
    bq_tag_t  tag;
    bq_data_t data;
  } bq_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// the first set request wins. Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_FU = 4
) (
  input  logic [NUM_FU-1:0]         req,
  input  logic [$clog2(NUM_FU)-1:0] ptr,
  output logic [NUM_FU-1:0]         grant,
  output logic [$clog2(NUM_FU)-1:0] grant_idx,
  output logic                      grant_valid
);

  localparam int IW = $clog2(NUM_FU);

  int idx;

  // Scan requests in priority order starting from ptr.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned; a missing default here would infer a latch.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(ptr) + k) % NUM_FU;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = IW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/broadcast_queue.sv
// broadcast_queue: latches FU completion pulses, arbitrates round-robin,
// enqueues one {tag, result} per cycle and drains it onto the CDB.
// Optional feature macro: BROADCAST_QUEUE_BYPASS_EN (empty-FIFO bypass onto
// the CDB in the grant cycle). Default build has no bypass.
module broadcast_queue
  import bq_pkg::*;
#(
  parameter int NUM_FU     = BQ_NUM_FU_DEFAULT,
  parameter int DATA_WIDTH = BQ_DATA_WIDTH_DEFAULT,
  parameter int TAG_WIDTH  = BQ_TAG_WIDTH_DEFAULT,
  parameter int DEPTH      = BQ_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_done,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
  output logic [NUM_FU-1:0]            fu_queued,
  output logic                         cdb_valid,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  input  logic                         cdb_stall,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM_FU);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [NUM_FU-1:0]     pend;
  logic [TAG_WIDTH-1:0]  pend_tag [NUM_FU];
  logic [IW-1:0]         rr_ptr;
  entry_t                mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  logic [TAG_WIDTH-1:0]  tag_arr [NUM_FU];
  logic [DATA_WIDTH-1:0] res_arr [NUM_FU];
  logic [NUM_FU-1:0]     arb_grant;
  logic [IW-1:0]         arb_idx;
  logic                  arb_valid;
  logic                  fifo_valid;
  logic                  pop;
  logic                  push;
  logic                  grant_fire;
  logic                  bypass;
  entry_t                win_entry;
  entry_t                head;

  // Split the flat per-FU buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      tag_arr[i] = fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
      res_arr[i] = fu_result[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_arbiter #(.NUM_FU(NUM_FU)) u_arb (
    .req         (pend),
    .ptr         (rr_ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign fifo_valid = (count != '0);
  assign pop        = fifo_valid & ~cdb_stall;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign grant_fire = arb_valid & ~flush & ((count < CW'(DEPTH)) | pop);
  // Result is read live on the grant cycle; the FU holds it until released.
  assign win_entry  = '{tag: pend_tag[arb_idx], data: res_arr[arb_idx]};
  assign head       = mem[rd_ptr];
  assign full       = (count == CW'(DEPTH));

`ifdef BROADCAST_QUEUE_BYPASS_EN
  assign bypass = grant_fire & ~fifo_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed winner accepted by the CDB never occupies a FIFO slot.
  assign push = grant_fire & ~(bypass & ~cdb_stall);

  // CDB drive: FIFO head, else the bypassed winner, else zeros.
  always_comb begin
    cdb_valid = fifo_valid;
    cdb_tag   = '0;
    cdb_data  = '0;
    if (fifo_valid) begin
      cdb_tag  = head.tag;
      cdb_data = head.data;
    end else if (bypass) begin
      cdb_valid = 1'b1;
      cdb_tag   = win_entry.tag;
      cdb_data  = win_entry.data;
    end
  end

  // Control state: pending latches, round-robin pointer, FIFO pointers, releases.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      pend      <= '0;
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fu_queued <= '0;
      for (int i = 0; i < NUM_FU; i++) pend_tag[i] <= '0;
    end else if (flush) begin
      // Release every FU holding a pending or just-arriving result.
      fu_queued <= pend | fu_done;
      pend      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      fu_queued <= grant_fire ? arb_grant : '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_done[i]) begin
          pend[i]     <= 1'b1;
          pend_tag[i] <= tag_arr[i];
        end else if (grant_fire && arb_grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (grant_fire)
        rr_ptr <= (arb_idx == IW'(NUM_FU - 1)) ? '0 : arb_idx + IW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; valid entries are defined by the pointers
    // and count, so clearing the array would only add reset fan-out.
    if (push) mem[wr_ptr] <= win_entry;
  end

`ifndef SYNTHESIS
  // A second done before release would silently overwrite the pending tag.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(|(fu_done & pend)))
      else $error("broadcast_queue: fu_done while pend already set");
  end
`endif

endmodule

// File: tb/tb_broadcast_queue.sv
// Randomised scoreboard bench for broadcast_queue with a transaction-level
// reference model (queues and arithmetic) of pending FUs, arbitration and FIFO.
module tb_broadcast_queue;
  import bq_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 7;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    fu_done;
  logic [N*TW-1:0] fu_tag;
  logic [N*DW-1:0] fu_result;
  logic [N-1:0]    fu_queued;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic            cdb_stall;
  logic [CW-1:0]   count;
  logic            full;

  broadcast_queue #(.NUM_FU(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fu_done(fu_done), .fu_tag(fu_tag),
    .fu_result(fu_result), .fu_queued(fu_queued), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_stall(cdb_stall),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_pend [N];
  logic [TW-1:0] m_ptag [N];
  bit          m_busy [N];
  int          m_rr;
  bq_entry_t   m_fifo [$];
  bq_entry_t   exp_q  [$];
  logic [N-1:0] exp_fuq;
  bit          exp_valid;
  int          exp_count;
  bit          d_grant, d_pop, d_bypass;
  int          d_w;
  bq_entry_t   d_entry;
  bit          mon_en = 1'b0;

  // Stimulus knobs
  int          done_pct, stall_pct, flush_pct, rst_cycles;
  logic [N-1:0] fu_mask;
  bit          dir_valid;
  logic [N-1:0] dir_done;
  logic [TW-1:0] dir_tag [N];
  logic [DW-1:0] dir_data [N];

  // Advance the model across the clock edge that just happened.
  task automatic apply();
    logic [N-1:0] qrel;
    qrel = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_busy[i] = 0; m_ptag[i] = '0; end
      m_rr = 0;
      m_fifo.delete();
      exp_q.delete();
    end else if (flush) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i] || fu_done[i]) qrel[i] = 1'b1;
        m_pend[i] = 0;
      end
      m_fifo.delete();
      exp_q.delete();
    end else begin
      if (d_pop) void'(m_fifo.pop_front());
      if (d_grant) begin
        if (!(d_bypass && !cdb_stall)) m_fifo.push_back(d_entry);
        m_pend[d_w] = 0;
        m_rr = (d_w + 1) % N;
        qrel[d_w] = 1'b1;
      end
      for (int i = 0; i < N; i++)
        if (fu_done[i]) begin m_pend[i] = 1; m_ptag[i] = fu_tag[i*TW +: TW]; end
    end
    for (int i = 0; i < N; i++) if (qrel[i]) m_busy[i] = 0;
    exp_fuq = qrel;
  endtask

  task automatic issue(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    fu_done[i] = 1'b1;
    fu_tag[i*TW +: TW] = t;
    fu_result[i*DW +: DW] = d;
    m_busy[i] = 1;
  endtask

  task automatic choose_inputs();
    rst = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    flush     = ($urandom_range(99) < flush_pct);
    cdb_stall = ($urandom_range(99) < stall_pct);
    fu_done   = '0;
    if (dir_valid) begin
      for (int i = 0; i < N; i++) if (dir_done[i] && !m_busy[i]) issue(i, dir_tag[i], dir_data[i]);
      dir_valid = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (!m_busy[i] && fu_mask[i] && $urandom_range(99) < done_pct)
          issue(i, TW'($urandom), $urandom);
    end
  endtask

  // Decide what happens in the current cycle from the current inputs.
  task automatic decide();
    int  n;
    bit  found;
    n = m_fifo.size();
    d_pop = (n > 0) && !cdb_stall;
    found = 0;
    d_w = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (!found && m_pend[idx]) begin found = 1; d_w = idx; end
    end
    d_grant = found && !flush && !rst && (n < D || d_pop);
    d_bypass = 0;
`ifdef BROADCAST_QUEUE_BYPASS_EN
    d_bypass = d_grant && (n == 0);
`endif
    if (d_grant) begin
      d_entry.tag  = m_ptag[d_w];
      d_entry.data = fu_result[d_w*DW +: DW];
      exp_q.push_back(d_entry);
    end
    exp_count = n;
    exp_valid = (n > 0) || d_bypass;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    apply();
    choose_inputs();
    decide();
  endtask

  // Monitor: compares DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 64'(count), 64'(exp_count));
      check("full", 64'(full), 64'(exp_count == D));
      check("fu_queued", 64'(fu_queued), 64'(exp_fuq));
      check("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
      if (cdb_valid) begin
        if (exp_q.size() == 0) begin
          check("cdb_expected_entry", 64'(exp_q.size()), 64'(1));
        end else begin
          check("cdb_tag", 64'(cdb_tag), 64'(exp_q[0].tag));
          check("cdb_data", 64'(cdb_data), 64'(exp_q[0].data));
          if (!cdb_stall) void'(exp_q.pop_front());
        end
      end else begin
        check("cdb_tag_idle", 64'(cdb_tag), 64'(0));
        check("cdb_data_idle", 64'(cdb_data), 64'(0));
      end
    end
  end

  task automatic set_knobs(input int dp, input int sp, input int fp, input logic [N-1:0] mask);
    done_pct = dp; stall_pct = sp; flush_pct = fp; fu_mask = mask;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cdb_stall = 1'b0;
    fu_done = '0; fu_tag = '0; fu_result = '0;
    rst_cycles = 2; dir_valid = 0; dir_done = '0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_busy[i] = 0; m_ptag[i] = '0; end
    m_rr = 0; exp_fuq = '0;
    set_knobs(0, 0, 0, '0);
    decide();
    tick();
    mon_en = 1'b1;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("reset_count", 64'(count), 64'(0));
    check("reset_cdb_valid", 64'(cdb_valid), 64'(0));

    // Contention: all four FUs at once, pointer at 0
    for (int i = 0; i < N; i++) begin dir_tag[i] = TW'(i + 1); dir_data[i] = $urandom; end
    dir_done = '1; dir_valid = 1;
    tick();
    repeat (2) tick();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("contention_order", 64'(cdb_tag), 64'(k + 1));
      check("contention_release", 64'(fu_queued), 64'(1 << k));
      tick();
    end
    repeat (4) tick();

    // Single FU: tag 0x05, result 0xDEADBEEF
    dir_tag[1] = 7'h05; dir_data[1] = 32'hDEADBEEF; dir_done = 4'b0010; dir_valid = 1;
    tick();
    repeat (2) tick();
    @(negedge clk);
`ifndef BROADCAST_QUEUE_BYPASS_EN
    check("single_valid", 64'(cdb_valid), 64'(1));
    check("single_tag", 64'(cdb_tag), 64'(5));
    check("single_data", 64'(cdb_data), 64'(32'hDEADBEEF));
`endif
    check("single_queued", 64'(fu_queued), 64'(4'b0010));
    tick();
    @(negedge clk);
    check("single_drained", 64'(count), 64'(0));
    repeat (3) tick();

    // Full: stalled consumer, every FU re-requesting
    set_knobs(100, 100, 0, '1);
    repeat (24) tick();
    @(negedge clk);
    check("full_count", 64'(count), 64'(D));
    check("full_flag", 64'(full), 64'(1));
    check("full_no_release", 64'(fu_queued), 64'(0));
    set_knobs(0, 0, 0, '1);
    tick();
    @(negedge clk);
    check("full_pop_push_count", 64'(count), 64'(D));
    set_knobs(0, 0, 0, '0);
    repeat (20) tick();

    // Fairness: FU0 and FU2 re-request on every release
    set_knobs(100, 0, 0, 4'b0101);
    repeat (30) tick();
    set_knobs(0, 0, 0, '0);
    repeat (8) tick();

    // Flush with queued entries and pending FUs
    set_knobs(100, 100, 0, '1);
    repeat (6) tick();
    set_knobs(0, 0, 100, '0);
    tick();
    set_knobs(0, 0, 0, '0);
    tick();
    @(negedge clk);
    check("flush_count", 64'(count), 64'(0));
    check("flush_cdb_valid", 64'(cdb_valid), 64'(0));
    set_knobs(50, 0, 0, '1);
    repeat (10) tick();

    // Random mix
    set_knobs(60, 30, 3, '1);
    repeat (1500) tick();
    set_knobs(40, 70, 1, '1);
    repeat (500) tick();

    // Drain
    set_knobs(0, 0, 0, '0);
    repeat (30) tick();
    @(negedge clk);
    check("drain_scoreboard", 64'(exp_q.size()), 64'(0));
    begin
      int busy_n;
      busy_n = 0;
      for (int i = 0; i < N; i++) busy_n += m_busy[i];
      check("drain_all_released", 64'(busy_n), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/broadcast_queue.md
# broadcast_queue

Result collection stage directly downstream of the functional units (FU_ADD, FU_OR, …). Each FU pulses `done` for one cycle with its execution tag and holds `result` stable until released; this block latches each pulse, arbitrates round-robin among pending FUs, and enqueues one result per cycle into a FIFO. It drains the FIFO onto the common data bus (CDB), one entry per cycle. It returns a one-cycle `queued` pulse to each FU whose result was accepted, which returns that FU to idle.

## Interface
Parameters:
- `NUM_FU`, 4: number of functional-unit ports (≥2).
- `DATA_WIDTH`, 32: result width.
- `TAG_WIDTH`, 7: execution tag width.
- `DEPTH`, 8: FIFO entries (power of two).

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of pending latches and FIFO (mispredict).
- `fu_done`  in  NUM_FU  per-FU one-cycle completion pulse.
- `fu_tag`  in  NUM_FU*TAG_WIDTH  per-FU tag, valid with `fu_done`; FU i at bits [i*TAG_WIDTH +: TAG_WIDTH].
- `fu_result`  in  NUM_FU*DATA_WIDTH  per-FU result, stable from `done` until its `queued`.
- `fu_queued`  out  NUM_FU  one-cycle release pulse per FU.
- `cdb_valid`  out  1  head entry is being broadcast.
- `cdb_tag`  out  TAG_WIDTH  broadcast tag.
- `cdb_data`  out  DATA_WIDTH  broadcast result.
- `cdb_stall`  in  1  consumer not accepting; head is held.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `full`  out  1  `count == DEPTH`.

## Operation
- Pending latch per FU: `fu_done[i]` sets `pend[i]` and captures `fu_tag[i]` into `pend_tag[i]`.
- Data is not latched at `done`; `fu_result[i]` is read live on the grant cycle.
- A `done` arriving while `pend[i]` is already set overwrites `pend_tag[i]`. This is a protocol violation and is flagged by a simulation-only assertion.
- Arbitration is combinational round-robin over `pend`, starting at `rr_ptr`.
- A grant is allowed only when `count < DEPTH`, or when `count == DEPTH` and a pop happens in the same cycle.
- On a grant to FU w:
  - {`pend_tag[w]`, `fu_result[w]`} is written at the FIFO tail.
  - `pend[w]` clears.
  - `rr_ptr` becomes (w+1) mod NUM_FU.
  - `fu_queued[w]` pulses in the following cycle.
- Pop: occurs when `cdb_valid & ~cdb_stall`; the head pointer advances. Push and pop in the same cycle leave `count` unchanged.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally; `count` is tracked separately.
- CDB outputs: `cdb_valid = (count != 0)`. `cdb_tag`/`cdb_data` show the head entry and are zero when empty.
- `flush`:
  - Clears the FIFO and `count`; no grant occurs that cycle.
  - Pulses `fu_queued` in the next cycle for every FU with `pend` set (or `done` this cycle), so no FU deadlocks non-idle.
  - Clears `pend`.
- `rst` clears all state. It generates no `fu_queued` pulses.
- Reset values: `fu_queued=0`, `cdb_valid=0`, `cdb_tag=0`, `cdb_data=0`, `count=0`, `full=0`, `rr_ptr=0`.
- If `rst` and `flush` are asserted together, `rst` wins.

## Timing
- `fu_done` in cycle t → `pend` set in t+1 → grant in t+1 if uncontended and not full → `fu_queued` high in t+2.
- Result → CDB latency: an entry written at the end of t+1 into an empty FIFO gives `cdb_valid` in t+2. Total is 2 cycles from `done`.
- Throughput: one enqueue and one broadcast per cycle. With K FUs pending, the last one is granted K-1 cycles after the first.
- While `cdb_stall` is high, `cdb_*` is held unchanged.

## Configuration
- `BROADCAST_QUEUE_BYPASS_EN`, when defined:
  - If the FIFO is empty and a grant occurs, the winner drives `cdb_*` combinationally in the grant cycle with `cdb_valid=1`.
  - If `cdb_stall=0` in that cycle, the entry is not written.
  - If `cdb_stall=1`, the entry is written to the FIFO as normal.
  - Latency from `done` becomes 1 cycle. `fu_queued` timing is unchanged.
- Undefined: no bypass; `cdb_*` comes from the FIFO head only.

## Structure
- Shared package `bq_pkg`:
  - `bq_entry_t` struct {tag, data}, parameterised via TAG_WIDTH/DATA_WIDTH typedef.
  - `BQ_DEPTH_DEFAULT` constant.
- Sub-module `rr_arbiter`: NUM_FU request vector plus pointer in; one-hot grant and encoded index out; purely combinational.
- The FIFO storage stays inline.

## Test plan
- **Single FU:** `fu_done[1]` at t with tag 0x05, result 0xDEADBEEF → `fu_queued[1]` at t+2. `cdb_valid` at t+2 with tag 0x05 and data 0xDEADBEEF; `count` returns to 0 at t+3.
- **Contention:** all 4 FUs pulse `done` at t (tags 1–4), `rr_ptr=0` → grants 0,1,2,3 in t+1..t+4. CDB shows tags 1,2,3,4 in t+2..t+5. Each `fu_queued[i]` pulse is exactly one cycle.
- **Full:** `cdb_stall=1`, 9 `done` events with DEPTH=8 → `full=1` and `count=8`. The ninth FU stays pending with no `fu_queued`. Drop the stall for 1 cycle → pop and grant happen together and `count` stays 8.
- **Round-robin fairness:** FU0 and FU2 re-request every cycle they are released → grants alternate 0,2,0,2; neither is starved.
- **Flush:** 3 entries queued and FU3 pending, assert `flush` → next cycle `count=0`, `cdb_valid=0`, `fu_queued[3]=1`. A new `done` afterwards is broadcast normally.
- **Bypass (macro defined):** empty FIFO, `fu_done[0]` at t → `cdb_valid` at t+1 with that tag, and `count` stays 0. Repeat with `cdb_stall=1` → `count=1` at t+2.
